// File: rtl/int_ctrl.sv
// int_ctrl: interrupt entry/exit sequencer sitting in front of fetch.
// Latches a rising int_req, waits for the pipe to go idle, stalls fetch for
// DRAIN_CYCLES, requests an EPC push, redirects fetch to the IVT, then tracks
// the service window until RTI and requests a flag restore.
// Optional macro INT_COUNT_EN adds an 8-bit saturating entry counter o_int_count.
module int_ctrl #(
    parameter int PC_W         = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int FLAG_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_pipe_busy,
    input  logic [FLAG_W-1:0] i_flags,
    input  logic              i_rti,
    output logic              o_stall_fetch,
    output logic              o_push_pc,
    output logic [PC_W-1:0]   o_epc,
    output logic              o_pc_sel_ivt,
    output logic [FLAG_W-1:0] o_saved_flags,
    output logic              o_restore_flags,
    output logic              o_int_active
`ifdef INT_COUNT_EN
    ,
    output logic [7:0]        o_int_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_PUSH, S_JUMP, S_SERVICE, S_RESTORE
    } state_t;

    localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              req_dly_q, req_dly_d;
    logic              pending_q, pending_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [PC_W-1:0]   epc_q, epc_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              stall_q, stall_d;
    logic              push_q, push_d;
    logic              ivt_q, ivt_d;
    logic              restore_q, restore_d;
    logic              active_q, active_d;
    logic              rise;
`ifdef INT_COUNT_EN
    logic [7:0]        count_q, count_d;
`endif

    assign rise = req_q & ~req_dly_q;

    // Next-state, request latching, capture on entry and registered output decode
    always_comb begin
        state_d   = state_q;
        req_d     = int_req;
        req_dly_d = req_q;
        pending_d = pending_q | rise;
        cnt_d     = cnt_q;
        epc_d     = epc_q;
        flags_d   = flags_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q && !i_pipe_busy) begin
                    state_d   = S_DRAIN;
                    cnt_d     = DRAIN_LD;
                    epc_d     = i_pc;
                    flags_d   = i_flags;
                    // an edge coinciding with entry belongs to this service
                    pending_d = 1'b0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_PUSH;
            end
            S_PUSH:    state_d = S_JUMP;
            S_JUMP:    state_d = S_SERVICE;
            S_SERVICE: if (i_rti) state_d = S_RESTORE;
            S_RESTORE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // outputs are decoded from the next state so they line up with state_q
        stall_d   = (state_d == S_DRAIN) || (state_d == S_PUSH);
        push_d    = (state_d == S_PUSH);
        ivt_d     = (state_d == S_JUMP);
        restore_d = (state_d == S_RESTORE);
        active_d  = (state_d != S_IDLE);
    end

`ifdef INT_COUNT_EN
    // Saturating count of DRAIN entries
    always_comb begin
        count_d = count_q;
        if (state_q == S_IDLE && state_d == S_DRAIN && count_q != 8'hFF)
            count_d = count_q + 8'd1;
    end
`endif

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            // both history bits set: a level already high at reset release is
            // not an edge, only a fresh 0->1 after reset requests service
            req_q     <= 1'b1;
            req_dly_q <= 1'b1;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            epc_q     <= '0;
            flags_q   <= '0;
            stall_q   <= 1'b0;
            push_q    <= 1'b0;
            ivt_q     <= 1'b0;
            restore_q <= 1'b0;
            active_q  <= 1'b0;
`ifdef INT_COUNT_EN
            count_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            req_dly_q <= req_dly_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            epc_q     <= epc_d;
            flags_q   <= flags_d;
            stall_q   <= stall_d;
            push_q    <= push_d;
            ivt_q     <= ivt_d;
            restore_q <= restore_d;
            active_q  <= active_d;
`ifdef INT_COUNT_EN
            count_q   <= count_d;
`endif
        end
    end

    assign o_stall_fetch   = stall_q;
    assign o_push_pc       = push_q;
    assign o_epc           = epc_q;
    assign o_pc_sel_ivt    = ivt_q;
    assign o_saved_flags   = flags_q;
    assign o_restore_flags = restore_q;
    assign o_int_active    = active_q;
`ifdef INT_COUNT_EN
    assign o_int_count     = count_q;
`endif

endmodule
